// File: rtl/ras_pkg.sv
// Shared defaults and checkpoint layout for the return-address stack.
package ras_pkg;

  localparam int RAS_ADDR_W = 17;
  localparam int RAS_DEPTH  = 16;
  localparam int RAS_CKPT_N = 4;
  localparam int RAS_PTR_W  = $clog2(RAS_DEPTH);
  localparam int RAS_CKPT_W = $clog2(RAS_CKPT_N);

  // Snapshot of the stack taken for mispredict recovery, at default sizes.
  // Only the top entry's value is kept; deeper entries are never repaired.
  typedef struct packed {
    logic [RAS_PTR_W-1:0]  ptr;
    logic [RAS_PTR_W:0]    count;
    logic [RAS_ADDR_W-1:0] top;
  } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt_file.sv
// Small checkpoint register file: one write port, one combinational read port.
module ras_ckpt_file
  import ras_pkg::*;
#(
  parameter int W      = $bits(ras_ckpt_t),
  parameter int CKPT_N = RAS_CKPT_N,
  parameter int CKPT_W = $clog2(CKPT_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [CKPT_W-1:0] i_wr_id,
  input  logic [W-1:0]      i_wr_data,
  input  logic [CKPT_W-1:0] i_rd_id,
  output logic [W-1:0]      o_rd_data
);

  logic [W-1:0] r_slot [CKPT_N];

  // Slots clear on reset and take a new snapshot only when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CKPT_N; i++) begin
        r_slot[i] <= '0;
      end
    end else if (i_we) begin
      r_slot[i_wr_id] <= i_wr_data;
    end
  end

  assign o_rd_data = r_slot[i_rd_id];

endmodule

// File: rtl/ras_ckpt_stack.sv
// Return-address stack with same-cycle push+pop, overflow/underflow pulses
// and checkpoint/restore so the instruction queue can roll back after a
// branch mispredict.
module ras_ckpt_stack
  import ras_pkg::*;
#(
  parameter int ADDR_W = RAS_ADDR_W,
  parameter int DEPTH  = RAS_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CKPT_N = RAS_CKPT_N,
  parameter int CKPT_W = $clog2(CKPT_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hci_rdy,
  input  logic              push_en,
  input  logic              pop_en,
  input  logic [ADDR_W-1:0] push_addr,
  output logic [ADDR_W-1:0] top,
  output logic              top_valid,
  input  logic              ckpt_en,
  input  logic [CKPT_W-1:0] ckpt_id,
  input  logic              restore_en,
  input  logic [CKPT_W-1:0] restore_id,
  output logic              overflow,
  output logic              underflow
);

  typedef struct packed {
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W:0]    count;
    logic [ADDR_W-1:0] top;
  } ckpt_t;

  localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W:0]    r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [PTR_W:0]    w_cnt_nxt;
  logic              w_wr_en;
  logic [PTR_W-1:0]  w_wr_idx;
  logic [ADDR_W-1:0] w_wr_data;
  logic              w_ovf_nxt;
  logic              w_unf_nxt;
  logic              w_ckpt_we;
  ckpt_t             w_ckpt_wr;
  ckpt_t             w_ckpt_rd;

  // A restore overrides every other request in the same cycle.
  assign w_push    = push_en && !restore_en;
  assign w_pop     = pop_en && !restore_en;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_FULL);
  assign w_ckpt_we = hci_rdy && ckpt_en && !restore_en;

  // Next pointer/count, the single memory write and the flag values.
  always_comb begin
    w_ptr_nxt = r_ptr;
    w_cnt_nxt = r_count;
    w_wr_en   = 1'b0;
    w_wr_idx  = r_ptr;
    w_wr_data = push_addr;
    w_ovf_nxt = 1'b0;
    w_unf_nxt = 1'b0;
    if (restore_en) begin
      w_ptr_nxt = w_ckpt_rd.ptr;
      w_cnt_nxt = w_ckpt_rd.count;
      w_wr_en   = 1'b1;
      w_wr_idx  = w_ckpt_rd.ptr;
      w_wr_data = w_ckpt_rd.top;
    end else if (w_push && w_pop) begin
      w_wr_en = 1'b1;
      if (w_empty) begin
        w_cnt_nxt = (PTR_W+1)'(1);
      end
    end else if (w_push) begin
      w_ptr_nxt = r_ptr + 1'b1;
      w_wr_en   = 1'b1;
      w_wr_idx  = r_ptr + 1'b1;
      w_ovf_nxt = w_full;
      if (!w_full) begin
        w_cnt_nxt = r_count + 1'b1;
      end
    end else if (w_pop) begin
      if (w_empty) begin
        w_unf_nxt = 1'b1;
      end else begin
        w_ptr_nxt = r_ptr - 1'b1;
        w_cnt_nxt = r_count - 1'b1;
      end
    end
  end

  // Snapshot of the post-update state; without a push the memory is not
  // written this cycle, so reading it at the next pointer is already current.
  always_comb begin
    w_ckpt_wr.ptr   = w_ptr_nxt;
    w_ckpt_wr.count = w_cnt_nxt;
    w_ckpt_wr.top   = w_push ? push_addr : r_mem[w_ptr_nxt];
  end

  // Stack state advances only while the pipeline is enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (hci_rdy) begin
      r_ptr       <= w_ptr_nxt;
      r_count     <= w_cnt_nxt;
      r_overflow  <= w_ovf_nxt;
      r_underflow <= w_unf_nxt;
      if (w_wr_en) begin
        r_mem[w_wr_idx] <= w_wr_data;
      end
    end
  end

  ras_ckpt_file #(
    .W      ($bits(ckpt_t)),
    .CKPT_N (CKPT_N),
    .CKPT_W (CKPT_W)
  ) u_ckpt_file (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_ckpt_we),
    .i_wr_id   (ckpt_id),
    .i_wr_data (w_ckpt_wr),
    .i_rd_id   (restore_id),
    .o_rd_data (w_ckpt_rd)
  );

  assign top       = w_empty ? '0 : r_mem[r_ptr];
  assign top_valid = !w_empty;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Bench for ras_ckpt_stack: directed scenarios followed by random traffic,
// every cycle compared against a circular-buffer reference model.
module tb_ras_ckpt_stack;

  localparam int ADDR_W = 17;
  localparam int DEPTH  = 16;
  localparam int CKPT_N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              hciRdy;
  logic              pushEn;
  logic              popEn;
  logic [ADDR_W-1:0] pushAddr;
  logic [ADDR_W-1:0] top;
  logic              topValid;
  logic              ckptEn;
  logic [1:0]        ckptId;
  logic              restoreEn;
  logic [1:0]        restoreId;
  logic              overflow;
  logic              underflow;

  int checks   = 0;
  int failures = 0;

  int mdlMem [DEPTH];
  int mdlPtr;
  int mdlCnt;
  int mdlOvf;
  int mdlUnf;
  int slotPtr [CKPT_N];
  int slotCnt [CKPT_N];
  int slotTop [CKPT_N];

  ras_ckpt_stack dut (
    .clk        (clk),
    .rst        (rst),
    .hci_rdy    (hciRdy),
    .push_en    (pushEn),
    .pop_en     (popEn),
    .push_addr  (pushAddr),
    .top        (top),
    .top_valid  (topValid),
    .ckpt_en    (ckptEn),
    .ckpt_id    (ckptId),
    .restore_en (restoreEn),
    .restore_id (restoreId),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  // Free-running clock, 10-unit period.
  always #5 clk = ~clk;

  // Everything the stack remembers is cleared by reset.
  task automatic modelReset();
    mdlPtr = 0;
    mdlCnt = 0;
    mdlOvf = 0;
    mdlUnf = 0;
    for (int i = 0; i < DEPTH; i++) mdlMem[i] = 0;
    for (int i = 0; i < CKPT_N; i++) begin
      slotPtr[i] = 0;
      slotCnt[i] = 0;
      slotTop[i] = 0;
    end
  endtask

  // One enabled clock edge of the return-address stack rules.
  task automatic modelStep();
    if (!hciRdy) return;
    mdlOvf = 0;
    mdlUnf = 0;
    if (restoreEn) begin
      mdlPtr = slotPtr[restoreId];
      mdlCnt = slotCnt[restoreId];
      mdlMem[mdlPtr] = slotTop[restoreId];
      return;
    end
    if (pushEn && popEn) begin
      mdlMem[mdlPtr] = int'(pushAddr);
      if (mdlCnt == 0) mdlCnt = 1;
    end else if (pushEn) begin
      if (mdlCnt == DEPTH) mdlOvf = 1;
      mdlPtr = (mdlPtr + 1) % DEPTH;
      mdlMem[mdlPtr] = int'(pushAddr);
      mdlCnt = (mdlCnt + 1 > DEPTH) ? DEPTH : mdlCnt + 1;
    end else if (popEn) begin
      if (mdlCnt == 0) begin
        mdlUnf = 1;
      end else begin
        mdlPtr = (mdlPtr + DEPTH - 1) % DEPTH;
        mdlCnt = mdlCnt - 1;
      end
    end
    if (ckptEn) begin
      slotPtr[ckptId] = mdlPtr;
      slotCnt[ckptId] = mdlCnt;
      slotTop[ckptId] = pushEn ? int'(pushAddr) : mdlMem[mdlPtr];
    end
  endtask

  // Single comparison point: counts the check and reports any difference.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the reference model.
  task automatic checkOutput(input string tag);
    check({tag, ".top"},       32'(top),       (mdlCnt != 0) ? 32'(mdlMem[mdlPtr]) : 32'd0);
    check({tag, ".topValid"},  32'(topValid),  32'(mdlCnt != 0));
    check({tag, ".overflow"},  32'(overflow),  32'(mdlOvf));
    check({tag, ".underflow"}, 32'(underflow), 32'(mdlUnf));
  endtask

  // Drive one cycle of inputs, step the model on the edge, check just after.
  task automatic applyStimulus(input string tag, input logic rdyV, input logic pushV,
                               input logic popV, input int addrV, input logic ckV,
                               input int ckIdV, input logic rsV, input int rsIdV);
    hciRdy    = rdyV;
    pushEn    = pushV;
    popEn     = popV;
    pushAddr  = ADDR_W'(addrV);
    ckptEn    = ckV;
    ckptId    = 2'(ckIdV);
    restoreEn = rsV;
    restoreId = 2'(rsIdV);
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  task automatic doPush(input string tag, input int a);
    applyStimulus(tag, 1'b1, 1'b1, 1'b0, a, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic doPop(input string tag);
    applyStimulus(tag, 1'b1, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic doIdle(input string tag);
    applyStimulus(tag, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
  endtask

  // Directed scenarios, random traffic, then a mid-operation reset.
  initial begin
    rst = 1'b1;
    hciRdy = 1'b0; pushEn = 1'b0; popEn = 1'b0; pushAddr = '0;
    ckptEn = 1'b0; ckptId = '0; restoreEn = 1'b0; restoreId = '0;
    modelReset();
    #12;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset");

    doPush("push100", 'h100);
    doPush("push104", 'h104);
    doPush("push108", 'h108);
    check("basic.top108", 32'(top), 32'h108);
    doPop("pop1");
    check("basic.top104", 32'(top), 32'h104);
    doPop("pop2");
    doPop("pop3");
    check("basic.emptyValid", 32'(topValid), 32'd0);

    doPop("popEmpty");
    check("underflow.pulse", 32'(underflow), 32'd1);
    doIdle("afterUnderflow");
    check("underflow.cleared", 32'(underflow), 32'd0);

    for (int i = 1; i <= DEPTH + 1; i++) doPush($sformatf("fill%0d", i), i);
    check("overflow.pulse", 32'(overflow), 32'd1);
    check("overflow.top", 32'(top), 32'h11);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain.top%0d", i), 32'(top), 32'(17 - i));
      doPop($sformatf("drain%0d", i));
    end
    check("drain.emptyValid", 32'(topValid), 32'd0);
    doPop("drainUnderflow");
    check("drain.underflow", 32'(underflow), 32'd1);

    doPush("push200", 'h200);
    applyStimulus("replace300", 1'b1, 1'b1, 1'b1, 'h300, 1'b0, 0, 1'b0, 0);
    check("replace.top", 32'(top), 32'h300);
    doPop("replacePop");
    check("replace.countOne", 32'(topValid), 32'd0);

    doPush("pushA0", 'hA0);
    applyStimulus("pushA4ckpt2", 1'b1, 1'b1, 1'b0, 'hA4, 1'b1, 2, 1'b0, 0);
    doPop("ckPop1");
    doPop("ckPop2");
    doPush("pushFF", 'hFF);
    applyStimulus("restore2", 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 2);
    check("restore.top", 32'(top), 32'hA4);
    doPop("restorePop");
    // Only the top entry is repaired; the 0xFF push overwrote the slot below.
    check("restore.staleBelow", 32'(top), 32'hFF);
    doPop("restorePop2");
    check("restore.countTwo", 32'(topValid), 32'd0);

    applyStimulus("push55ckpt1", 1'b1, 1'b1, 1'b0, 'h55, 1'b1, 1, 1'b0, 0);
    applyStimulus("restoreWins", 1'b1, 1'b1, 1'b0, 'h77, 1'b1, 1, 1'b1, 1);
    check("restoreWins.top", 32'(top), 32'h55);
    doPush("push99", 'h99);
    applyStimulus("restoreAgain", 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1);
    check("restoreWins.slotKept", 32'(top), 32'h55);

    doPop("holdPop1");
    doPop("holdPop2");
    check("hold.underflowSet", 32'(underflow), 32'd1);
    applyStimulus("holdFrozenPush", 1'b0, 1'b1, 1'b0, 'h123, 1'b0, 0, 1'b0, 0);
    check("hold.underflowHeld", 32'(underflow), 32'd1);
    check("hold.noPush", 32'(topValid), 32'd0);
    doIdle("holdRelease");

    for (int n = 0; n < 600; n++) begin
      applyStimulus($sformatf("rand%0d", n),
                    $urandom_range(0, 9) != 0,
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 2) == 0,
                    int'($urandom_range(0, 'h1FFFF)),
                    $urandom_range(0, 3) == 0,
                    int'($urandom_range(0, CKPT_N - 1)),
                    $urandom_range(0, 11) == 0,
                    int'($urandom_range(0, CKPT_N - 1)));
    end

    for (int i = 0; i < 3; i++) doPush($sformatf("preReset%0d", i), 'h400 + i);
    applyStimulus("ckptBeforeReset", 1'b1, 1'b0, 1'b0, 0, 1'b1, 0, 1'b0, 0);
    hciRdy = 1'b1; pushEn = 1'b1; pushAddr = 'h777; ckptEn = 1'b1; ckptId = 2'd3;
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("midReset");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("restoreAfterReset", 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 0);
    check("midReset.slotCleared", 32'(topValid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
